fetch_pc_unit: RTL and testbench

- Fetch stage directly upstream of the fetch/decode pipeline register.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Presents registered rd/pcf/pcplus4f plus validf to the fetch/decode register.
- Handles hazard-unit stalls through a 1-entry skid buffer, and execute-stage redirects by flushing and discarding stale responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_pc_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// the NOP bubble instruction and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that absorbs a fetched instruction
// while the fetch/decode register is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     unload,
    input  logic                     clear,
    input  logic [DATA_WIDTH-1:0]    instr_in,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     full
);

    logic [DATA_WIDTH-1:0]    instr_r;
    logic [ADDRESS_WIDTH-1:0] pc_r;
    logic                     full_r;

    // Entry storage; a redirect clear wins over a simultaneous load or unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= '0;
            pc_r    <= '0;
            full_r  <= 1'b0;
        end else if (clear) begin
            full_r  <= 1'b0;
        end else if (load) begin
            instr_r <= instr_in;
            pc_r    <= pc_in;
            full_r  <= 1'b1;
        end else if (unload) begin
            full_r  <= 1'b0;
        end
    end

    assign instr = instr_r;
    assign pc    = pc_r;
    assign full  = full_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, talks req/ack to instruction memory and feeds the
// fetch/decode register. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stallf,
    input  logic                     pcsrce,
    input  logic [ADDRESS_WIDTH-1:0] pctargete,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    rd,
    output logic [ADDRESS_WIDTH-1:0] pcf,
    output logic [ADDRESS_WIDTH-1:0] pcplus4f,
    output logic                     validf
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [31:0]              drop_count
`endif
);

    localparam logic [ADDRESS_WIDTH-1:0] STEP_S     = ADDRESS_WIDTH'(PC_STEP);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_PC4  = RESET_PC + STEP_S;
    localparam logic [DATA_WIDTH-1:0]    NOP_S      = DATA_WIDTH'(NOP_INSTR);

    fetch_state_t             state_r, state_s;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_r, fetch_pc_s;
    logic [ADDRESS_WIDTH-1:0] stale_pc_r, stale_pc_s;
    logic [DATA_WIDTH-1:0]    rd_r, rd_s;
    logic [ADDRESS_WIDTH-1:0] pcf_r, pcf_s;
    logic [ADDRESS_WIDTH-1:0] pcplus4f_r, pcplus4f_s;
    logic                     validf_r, validf_s;

    logic                     consume_s;
    logic                     drop_evt_s;
    logic                     skid_load_s, skid_unload_s, skid_clear_s;
    logic [DATA_WIDTH-1:0]    skid_instr_s;
    logic [ADDRESS_WIDTH-1:0] skid_pc_s;
    logic                     skid_full_s;

    assign consume_s = validf_r & ~stallf;

    fetch_skid_buf #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load_s),
        .unload   (skid_unload_s),
        .clear    (skid_clear_s),
        .instr_in (imem_rdata),
        .pc_in    (fetch_pc_r),
        .instr    (skid_instr_s),
        .pc       (skid_pc_s),
        .full     (skid_full_s)
    );

    // Memory request bus is a pure function of the FSM state.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc_r;
        case (state_r)
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = fetch_pc_r;
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = stale_pc_r;
            end
            FULL: begin
                imem_req  = 1'b0;
                imem_addr = fetch_pc_r;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = fetch_pc_r;
            end
        endcase
    end

    // Next-state and next-output logic; redirect outranks ack and stall.
    always_comb begin
        state_s       = state_r;
        fetch_pc_s    = fetch_pc_r;
        stale_pc_s    = stale_pc_r;
        rd_s          = rd_r;
        pcf_s         = pcf_r;
        pcplus4f_s    = pcplus4f_r;
        validf_s      = consume_s ? 1'b0 : validf_r;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;
        drop_evt_s    = 1'b0;
        if (pcsrce) begin
            fetch_pc_s   = pctargete;
            validf_s     = 1'b0;
            rd_s         = NOP_S;
            skid_clear_s = 1'b1;
            case (state_r)
                REQ: begin
                    if (imem_ack) begin
                        drop_evt_s = 1'b1;
                        state_s    = REQ;
                    end else begin
                        stale_pc_s = fetch_pc_r;
                        state_s    = DROP;
                    end
                end
                DROP: begin
                    drop_evt_s = imem_ack;
                    state_s    = DROP;
                end
                FULL:    state_s = REQ;
                default: state_s = REQ;
            endcase
        end else begin
            case (state_r)
                REQ: begin
                    if (imem_ack && (!validf_r || !stallf)) begin
                        rd_s       = imem_rdata;
                        pcf_s      = fetch_pc_r;
                        pcplus4f_s = fetch_pc_r + STEP_S;
                        validf_s   = 1'b1;
                        fetch_pc_s = fetch_pc_r + STEP_S;
                    end else if (imem_ack) begin
                        skid_load_s = 1'b1;
                        fetch_pc_s  = fetch_pc_r + STEP_S;
                        state_s     = FULL;
                    end else begin
                        state_s = REQ;
                    end
                end
                FULL: begin
                    if (!stallf) begin
                        rd_s          = skid_instr_s;
                        pcf_s         = skid_pc_s;
                        pcplus4f_s    = skid_pc_s + STEP_S;
                        validf_s      = skid_full_s;
                        skid_unload_s = 1'b1;
                        state_s       = REQ;
                    end else begin
                        state_s = FULL;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        drop_evt_s = 1'b1;
                        state_s    = REQ;
                    end else begin
                        state_s = DROP;
                    end
                end
                default: state_s = REQ;
            endcase
        end
    end

    // State, PC and fetch/decode-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= REQ;
            fetch_pc_r <= RESET_PC;
            stale_pc_r <= RESET_PC;
            rd_r       <= NOP_S;
            pcf_r      <= RESET_PC;
            pcplus4f_r <= RESET_PC4;
            validf_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            stale_pc_r <= stale_pc_s;
            rd_r       <= rd_s;
            pcf_r      <= pcf_s;
            pcplus4f_r <= pcplus4f_s;
            validf_r   <= validf_s;
        end
    end

    assign rd       = rd_r;
    assign pcf      = pcf_r;
    assign pcplus4f = pcplus4f_r;
    assign validf   = validf_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;
    logic [31:0] drop_count_r;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'd0;
            drop_count_r  <= 32'd0;
        end else begin
            fetch_count_r <= fetch_count_r + {31'd0, consume_s};
            drop_count_r  <= drop_count_r + {31'd0, drop_evt_s};
        end
    end

    assign fetch_count = fetch_count_r;
    assign drop_count  = drop_count_r;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; the bench acts as the
// instruction memory (zero-wait or manually acked).
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stallf;
    logic        pcsrce;
    logic [31:0] pctargete;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] rd;
    logic [31:0] pcf;
    logic [31:0] pcplus4f;
    logic        validf;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] drop_count;
`endif

    logic zw;
    logic ack_man;
    int   n_checks;
    int   n_fail;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00A0_0093 : {a[23:0], 8'h13};
    endfunction

    assign imem_ack   = zw ? imem_req : ack_man;
    assign imem_rdata = instr_at(imem_addr);

    fetch_pc_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stallf     (stallf),
        .pcsrce     (pcsrce),
        .pctargete  (pctargete),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rd         (rd),
        .pcf        (pcf),
        .pcplus4f   (pcplus4f),
        .validf     (validf)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc);
        check_val({tag, ".validf"}, {31'd0, validf}, {31'd0, v});
        check_val({tag, ".pcf"}, pcf, pc);
        check_val({tag, ".pcplus4f"}, pcplus4f, pc + 32'd4);
        if (v) check_val({tag, ".rd"}, rd, instr_at(pc));
        else   check_val({tag, ".rd_nop"}, rd, 32'h0000_0013);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; stallf = 1'b0; pcsrce = 1'b0; pctargete = 32'd0;
        zw = 1'b0; ack_man = 1'b0;
        #12;
        check_out("reset", 1'b0, 32'h0);
        check_val("reset.req", {31'd0, imem_req}, 32'd1);
        check_val("reset.addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check_val("reset.drop_count", drop_count, 32'd0);
        check_val("reset.fetch_count", fetch_count, 32'd0);
`endif
        rst_n = 1'b1; zw = 1'b1;

        // zero-wait: one instruction per cycle
        step();
        check_out("zw0", 1'b1, 32'h0);
        check_val("zw0.rd_lit", rd, 32'h00A0_0093);
        check_val("zw0.addr", imem_addr, 32'h4);
        step();
        check_out("zw1", 1'b1, 32'h4);

        // 3-cycle ack latency at 0x8
        zw = 1'b0; ack_man = 1'b0;
        check_val("lat.addr1", imem_addr, 32'h8);
        step();
        check_val("lat.valid1", {31'd0, validf}, 32'd0);
        check_val("lat.addr2", imem_addr, 32'h8);
        step();
        check_val("lat.valid2", {31'd0, validf}, 32'd0);
        check_val("lat.addr3", imem_addr, 32'h8);
        ack_man = 1'b1;
        step();
        check_out("lat.ack", 1'b1, 32'h8);
        check_val("lat.next_addr", imem_addr, 32'hC);
        ack_man = 1'b0; zw = 1'b1;

        // stall with skid capture
        step();
        check_out("run.c", 1'b1, 32'hC);
        step();
        check_out("run.10", 1'b1, 32'h10);
        stallf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("stall", 1'b1, 32'h10);
            check_val("stall.req", {31'd0, imem_req}, 32'd0);
        end
        stallf = 1'b0;
        step();
        check_out("skid.out", 1'b1, 32'h14);
        check_val("skid.req", {31'd0, imem_req}, 32'd1);
        check_val("skid.addr", imem_addr, 32'h18);
        step();
        check_out("resume", 1'b1, 32'h18);

        // redirect while waiting on 0x20
        step();
        check_out("run.1c", 1'b1, 32'h1C);
        zw = 1'b0; ack_man = 1'b0;
        step();
        check_val("wait20.addr", imem_addr, 32'h20);
        check_val("wait20.valid", {31'd0, validf}, 32'd0);
        pcsrce = 1'b1; pctargete = 32'h100;
        step();
        pcsrce = 1'b0;
        check_val("drop.valid", {31'd0, validf}, 32'd0);
        check_val("drop.rd", rd, 32'h0000_0013);
        check_val("drop.req", {31'd0, imem_req}, 32'd1);
        check_val("drop.addr", imem_addr, 32'h20);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        check_val("drop.discard_valid", {31'd0, validf}, 32'd0);
        check_val("drop.new_addr", imem_addr, 32'h100);
        zw = 1'b1;
        step();
        check_out("tgt", 1'b1, 32'h100);

        // redirect from FULL clears skid
        stallf = 1'b1;
        step();
        check_val("full.req", {31'd0, imem_req}, 32'd0);
        pcsrce = 1'b1; pctargete = 32'h200;
        step();
        pcsrce = 1'b0;
        check_val("fullredir.valid", {31'd0, validf}, 32'd0);
        check_val("fullredir.req", {31'd0, imem_req}, 32'd1);
        check_val("fullredir.addr", imem_addr, 32'h200);
        step();
        check_out("fullredir.first", 1'b1, 32'h200);

        // redirect coincident with ack while output occupied
        pcsrce = 1'b1; pctargete = 32'h300;
        step();
        pcsrce = 1'b0;
        check_val("coinc.valid", {31'd0, validf}, 32'd0);
        check_val("coinc.rd", rd, 32'h0000_0013);
        check_val("coinc.req", {31'd0, imem_req}, 32'd1);
        check_val("coinc.addr", imem_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
        check_val("coinc.drop_count", drop_count, 32'd2);
`endif
        stallf = 1'b0;
        step();
        check_out("coinc.next", 1'b1, 32'h300);

        // wrap at top of address space
        pcsrce = 1'b1; pctargete = 32'hFFFF_FFFC;
        step();
        pcsrce = 1'b0;
        check_val("wrap.addr_pre", imem_addr, 32'hFFFF_FFFC);
        step();
        check_val("wrap.pcf", pcf, 32'hFFFF_FFFC);
        check_val("wrap.pcplus4f", pcplus4f, 32'h0);
        check_val("wrap.rd", rd, instr_at(32'hFFFF_FFFC));
        check_val("wrap.addr", imem_addr, 32'h0);

        // async reset mid-wait
        zw = 1'b0; stallf = 1'b1;
        step();
        check_val("hold.valid", {31'd0, validf}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("areset", 1'b0, 32'h0);
        check_val("areset.addr", imem_addr, 32'h0);
        check_val("areset.req", {31'd0, imem_req}, 32'd1);
        #10;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
